// File: rtl/reg_file_if.sv
// Register-file bus: one write port and two read ports.
// The master drives addresses and write data; the slave returns read data.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] Data_In;
    logic [ADDR_W-1:0] Waddr;
    logic              W_en;
    logic [ADDR_W-1:0] Rd_Addr1;
    logic [ADDR_W-1:0] Rd_Addr2;
    logic [DATA_W-1:0] Data_out1;
    logic [DATA_W-1:0] Data_out2;

    modport master (
        output Data_In, Waddr, W_en, Rd_Addr1, Rd_Addr2,
        input  Data_out1, Data_out2
    );

    modport slave (
        input  Data_In, Waddr, W_en, Rd_Addr1, Rd_Addr2,
        output Data_out1, Data_out2
    );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: 2 combinational read ports with
// write-first bypass, 1 write port, register 0 hard-wired to zero.
module reg_file_rd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                                rst_n,
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [ADDR_W-1:0]                   raddr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
    output logic [DATA_W-1:0]                   rdata
);
    // Reads are forced to zero while in reset, which also disables the bypass.
    always_comb begin
        rdata = '0;
        if (rst_n) begin
            if (we && (waddr != '0) && (raddr == waddr))
                rdata = wdata;
            else
                rdata = regs[raddr];
        end
    end
endmodule

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic        clock,
    input logic        reset,
    reg_file_if.slave  bus
);
    localparam int NREG   = 2**ADDR_W;
    localparam int NPORTS = 2;

    logic [NREG-1:0][DATA_W-1:0]   regs;
    logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NPORTS-1:0][DATA_W-1:0] rd_data;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            regs <= '0;
        else if (bus.W_en && (bus.Waddr != '0))
            regs[bus.Waddr] <= bus.Data_In;
    end

    assign rd_addr = {bus.Rd_Addr2, bus.Rd_Addr1};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        reg_file_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
            .rst_n (reset),
            .we    (bus.W_en),
            .waddr (bus.Waddr),
            .wdata (bus.Data_In),
            .raddr (rd_addr[p]),
            .regs  (regs),
            .rdata (rd_data[p])
        );
    end

    assign bus.Data_out1 = rd_data[0];
    assign bus.Data_out2 = rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against an array-based model
// of the register contents.
module tb_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 2**AW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #50 clock = ~clock;

    reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] model [N];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    // Expected combinational read value for the current inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!reset) return '0;
        if (bus.W_en && bus.Waddr != 0 && a == bus.Waddr) return bus.Data_In;
        return model[a];
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset && bus.W_en && bus.Waddr != 0) model[bus.Waddr] = bus.Data_In;
        #1;
    endtask

    task automatic test_reset();
        bus.W_en = 1'b0; bus.Waddr = '0; bus.Data_In = '0;
        reset = 1'b0;
        model_clear();
        #1;
        for (int a = 0; a < N; a++) begin
            bus.Rd_Addr1 = AW'(a); bus.Rd_Addr2 = AW'(N-1-a); #1;
            tests_run++;
            if (bus.Data_out1 !== '0) begin
                tests_failed++; $display("FAIL reset_rd1 addr=%0d got=%h exp=0", a, bus.Data_out1);
            end
            tests_run++;
            if (bus.Data_out2 !== '0) begin
                tests_failed++; $display("FAIL reset_rd2 addr=%0d got=%h exp=0", N-1-a, bus.Data_out2);
            end
        end
        @(negedge clock); reset = 1'b1; #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            bus.W_en = 1'b1; bus.Waddr = AW'(i); bus.Data_In = DW'(i);
            tick();
        end
        bus.W_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.Rd_Addr1 = AW'(i); bus.Rd_Addr2 = AW'(i); #1;
            tests_run++;
            if (bus.Data_out1 !== DW'(i) || bus.Data_out2 !== DW'(i)) begin
                tests_failed++;
                $display("FAIL fill addr=%0d got=%h/%h exp=%h", i, bus.Data_out1, bus.Data_out2, DW'(i));
            end
        end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < N/2; k++) begin
            bus.Rd_Addr1 = AW'(2*k); bus.Rd_Addr2 = AW'(2*k+1); #1;
            tests_run++;
            if (bus.Data_out1 !== DW'(2*k) || bus.Data_out2 !== DW'(2*k+1)) begin
                tests_failed++;
                $display("FAIL alternate k=%0d got=%h/%h exp=%h/%h", k, bus.Data_out1, bus.Data_out2,
                         DW'(2*k), DW'(2*k+1));
            end
        end
    endtask

    task automatic test_same_addr();
        bus.W_en = 1'b0; bus.Rd_Addr1 = 5'd10; bus.Rd_Addr2 = 5'd10; #1;
        tests_run++;
        if (bus.Data_out1 !== 32'd10 || bus.Data_out2 !== 32'd10) begin
            tests_failed++; $display("FAIL same_addr got=%h/%h exp=a/a", bus.Data_out1, bus.Data_out2);
        end
    endtask

    task automatic test_bypass();
        bus.W_en = 1'b1; bus.Waddr = 5'd10; bus.Data_In = 32'd1;
        bus.Rd_Addr1 = 5'd10; bus.Rd_Addr2 = 5'd10; #1;
        tests_run++;
        if (bus.Data_out1 !== 32'd1 || bus.Data_out2 !== 32'd1) begin
            tests_failed++; $display("FAIL bypass_pre got=%h/%h exp=1/1", bus.Data_out1, bus.Data_out2);
        end
        tick();
        bus.W_en = 1'b0; bus.Data_In = 32'h5555_AAAA; #1;
        tests_run++;
        if (bus.Data_out1 !== 32'd1 || bus.Data_out2 !== 32'd1) begin
            tests_failed++; $display("FAIL bypass_post got=%h/%h exp=1/1", bus.Data_out1, bus.Data_out2);
        end
    endtask

    task automatic test_wen_low();
        bus.W_en = 1'b0; bus.Waddr = 5'd5; bus.Data_In = 32'hDEAD_BEEF;
        bus.Rd_Addr1 = 5'd5; bus.Rd_Addr2 = 5'd5;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if (bus.Data_out1 !== 32'd5 || bus.Data_out2 !== 32'd5) begin
                tests_failed++;
                $display("FAIL wen_low cyc=%0d got=%h/%h exp=5", c, bus.Data_out1, bus.Data_out2);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            bus.W_en    = ($urandom_range(0, 3) != 0);
            bus.Waddr   = AW'($urandom_range(0, N-1));
            bus.Data_In = $urandom;
            bus.Rd_Addr1 = ($urandom_range(0, 3) == 0) ? bus.Waddr : AW'($urandom_range(0, N-1));
            bus.Rd_Addr2 = ($urandom_range(0, 3) == 0) ? bus.Rd_Addr1 : AW'($urandom_range(0, N-1));
            #1;
            tests_run++;
            if (bus.Data_out1 !== exp_rd(bus.Rd_Addr1) || bus.Data_out2 !== exp_rd(bus.Rd_Addr2)) begin
                tests_failed++;
                $display("FAIL random it=%0d ra=%0d/%0d got=%h/%h exp=%h/%h", it, bus.Rd_Addr1, bus.Rd_Addr2,
                         bus.Data_out1, bus.Data_out2, exp_rd(bus.Rd_Addr1), exp_rd(bus.Rd_Addr2));
            end
            tick();
        end
        bus.W_en = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [DW-1:0] v;
        v = $urandom | 32'h1;
        @(posedge clock); #1;
        reset = 1'b0; model_clear();
        bus.W_en = 1'b1; bus.Waddr = 5'd7; bus.Data_In = v;
        // Whole sweep fits inside half a clock period: no edge involved.
        for (int a = 0; a < N; a++) begin
            bus.Rd_Addr1 = AW'(a); bus.Rd_Addr2 = AW'(a); #1;
            tests_run++;
            if (bus.Data_out1 !== '0 || bus.Data_out2 !== '0) begin
                tests_failed++;
                $display("FAIL midrun_reset addr=%0d got=%h/%h exp=0", a, bus.Data_out1, bus.Data_out2);
            end
        end
        bus.Rd_Addr1 = 5'd7; bus.Rd_Addr2 = 5'd7;
        tick(); tick();
        tests_run++;
        if (bus.Data_out1 !== '0 || bus.Data_out2 !== '0) begin
            tests_failed++; $display("FAIL reset_write_blocked got=%h/%h exp=0", bus.Data_out1, bus.Data_out2);
        end
        @(negedge clock); reset = 1'b1;
        bus.W_en = 1'b0; #1;
        tests_run++;
        if (bus.Data_out1 !== '0) begin
            tests_failed++; $display("FAIL post_reset_reg7 got=%h exp=0", bus.Data_out1);
        end
        bus.W_en = 1'b1;
        tick();
        bus.W_en = 1'b0; #1;
        tests_run++;
        if (bus.Data_out1 !== v || bus.Data_out2 !== v) begin
            tests_failed++;
            $display("FAIL first_edge_write got=%h/%h exp=%h", bus.Data_out1, bus.Data_out2, v);
        end
    endtask

    initial begin
        bus.W_en = 1'b0; bus.Waddr = '0; bus.Data_In = '0;
        bus.Rd_Addr1 = '0; bus.Rd_Addr2 = '0;
        model_clear();
        test_reset();
        test_fill();
        test_alternate();
        test_same_addr();
        test_bypass();
        test_wen_low();
        test_random();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count = 2**ADDR_W (32 by default).
REQ-003 clock  input  1  single clock; all writes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears every register.
REQ-005 Data_In  input  DATA_W  write data.
REQ-006 Waddr  input  ADDR_W  write address.
REQ-007 W_en  input  1  write enable, active-high.
REQ-008 Rd_Addr1  input  ADDR_W  read port 1 address.
REQ-009 Data_out1  output  DATA_W  read port 1 data.
REQ-010 Rd_Addr2  input  ADDR_W  read port 2 address.
REQ-011 Data_out2  output  DATA_W  read port 2 data.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits, with 2 independent read ports and 1 write port.
REQ-013 On a rising clock edge with W_en=1 and Waddr!=0, register[Waddr] SHALL take Data_In; W_en=0 leaves all registers unchanged.
REQ-014 Register 0 SHALL always read 0; writes to address 0 are ignored.
REQ-015 Reads SHALL be combinational: Data_outN = register[Rd_AddrN] in the same cycle, zero clock latency.
REQ-016 Read-during-write: when W_en=1, Waddr!=0 and Rd_AddrN==Waddr, Data_outN SHALL present Data_In (write-first bypass) before the edge; after the edge the stored value matches.
REQ-017 Both read ports SHALL return identical data when Rd_Addr1==Rd_Addr2, including during bypass.
REQ-018 Addresses SHALL wrap modulo 2**ADDR_W; no out-of-range state exists.
REQ-019 X/unknown on W_en SHALL NOT be used to infer a write; benches drive W_en defined after reset.

Reset
REQ-020 While reset=0, all registers SHALL be 0 immediately (asynchronous), independent of clock.
REQ-021 While reset=0, writes SHALL be blocked, and Data_out1/Data_out2 SHALL read 0 for every address (bypass disabled).
REQ-022 Reset deassertion SHALL take effect for writes on the first rising edge at which reset=1.
REQ-023 Asserting reset mid-operation SHALL discard all prior contents; no write completes on an edge coincident with reset=0.

Verification
REQ-024 Assert reset=0 mid-run after writes -> both outputs read 0 for all 32 addresses without a clock edge.
REQ-025 Write value i to address i for i=0..31 with W_en=1 -> reading address i returns i, address 0 returns 0.
REQ-026 Alternate reads (even addresses on Rd_Addr1, odd on Rd_Addr2) after REQ-025 fill -> Data_out1=even i, Data_out2=odd i, same cycle as address change.
REQ-027 Rd_Addr1=Rd_Addr2=10 -> both outputs 10.
REQ-028 Rd_Addr1=Rd_Addr2=Waddr=10, W_en=1, Data_In=1 -> both outputs 1 before the edge (bypass), register 10 holds 1 after the edge.
REQ-029 W_en=0 with Waddr=5, Data_In=0xDEADBEEF across several edges -> register 5 unchanged.
